seq_pattern_tx: RTL

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pattern_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: repeats a PAT_W-bit pattern MSB first for rep_cnt frames with
// optional idle gaps between frames; all outputs registered (Moore). Rev 1.0
`default_nettype none

module seq_pattern_tx #(
  parameter int                PAT_W    = 5,
  parameter logic [PAT_W-1:0]  DEF_PAT  = 'b10101,
  parameter logic              IDLE_BIT = 1'b0,
  parameter int                REP_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [2:0]       gap_len,
  input  logic             abort,
  output logic             o,
  output logic             o_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pat, pat_nxt;
  logic [IDX_W-1:0] bit_idx, bit_idx_nxt;
  logic [REP_W-1:0] frames_left, frames_left_nxt;
  logic [2:0]       gap_cfg, gap_cfg_nxt;
  logic [2:0]       gap_left, gap_left_nxt;
  logic             o_nxt, o_valid_nxt, frame_start_nxt, busy_nxt, done_nxt;
  logic [PAT_W-1:0] tx_pat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pat         <= DEF_PAT;
      bit_idx     <= '0;
      frames_left <= '0;
      gap_cfg     <= '0;
      gap_left    <= '0;
      o           <= IDLE_BIT;
      o_valid     <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pat         <= pat_nxt;
      bit_idx     <= bit_idx_nxt;
      frames_left <= frames_left_nxt;
      gap_cfg     <= gap_cfg_nxt;
      gap_left    <= gap_left_nxt;
      o           <= o_nxt;
      o_valid     <= o_valid_nxt;
      frame_start <= frame_start_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

  // A load in the same cycle as start must already be the transmitted pattern.
  assign tx_pat = pat_load ? pat_in : pat;

  always_comb begin
    state_nxt       = state;
    pat_nxt         = pat;
    bit_idx_nxt     = bit_idx;
    frames_left_nxt = frames_left;
    gap_cfg_nxt     = gap_cfg;
    gap_left_nxt    = gap_left;
    o_nxt           = IDLE_BIT;
    o_valid_nxt     = 1'b0;
    frame_start_nxt = 1'b0;
    busy_nxt        = 1'b0;
    done_nxt        = 1'b0;

    case (state)
      IDLE: begin
        if (pat_load) pat_nxt = pat_in;
        if (start && !abort) begin
          state_nxt       = SHIFT;
          frames_left_nxt = (rep_cnt == '0) ? REP_W'(1) : rep_cnt;
          gap_cfg_nxt     = gap_len;
          bit_idx_nxt     = LAST_IDX;
          o_nxt           = tx_pat[PAT_W-1];
          o_valid_nxt     = 1'b1;
          frame_start_nxt = 1'b1;
          busy_nxt        = 1'b1;
        end
      end

      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (bit_idx != '0) begin
          bit_idx_nxt = bit_idx - 1'b1;
          o_nxt       = pat[bit_idx - 1'b1];
          o_valid_nxt = 1'b1;
          busy_nxt    = 1'b1;
        end else if (frames_left <= REP_W'(1)) begin
          state_nxt       = IDLE;
          frames_left_nxt = '0;
          done_nxt        = 1'b1;
        end else begin
          frames_left_nxt = frames_left - 1'b1;
          busy_nxt        = 1'b1;
          if (gap_cfg == 3'd0) begin
            bit_idx_nxt     = LAST_IDX;
            o_nxt           = pat[PAT_W-1];
            o_valid_nxt     = 1'b1;
            frame_start_nxt = 1'b1;
          end else begin
            state_nxt    = GAP;
            gap_left_nxt = gap_cfg;
          end
        end
      end

      GAP: begin
        // gap_left counts the idle cycles still to show, including this one.
        if (abort) begin
          state_nxt = IDLE;
        end else if (gap_left <= 3'd1) begin
          state_nxt       = SHIFT;
          gap_left_nxt    = '0;
          bit_idx_nxt     = LAST_IDX;
          o_nxt           = pat[PAT_W-1];
          o_valid_nxt     = 1'b1;
          frame_start_nxt = 1'b1;
          busy_nxt        = 1'b1;
        end else begin
          gap_left_nxt = gap_left - 1'b1;
          busy_nxt     = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire
